// File: rtl/noc_link_pkg.sv
// noc_link_pkg: flit/VC-state types and width helpers for the credit-based link
package noc_link_pkg;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;
    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    localparam int DEFAULT_BUFFER_SIZE = 8;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int vc_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter: one VC's credit count, saturating at BUFFER_SIZE with an overflow flag
module credit_counter
    import noc_link_pkg::*;
#(
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    localparam int CW = credit_width(BUFFER_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic          credit,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

    logic [CW-1:0] count_next;

    always_comb begin
        overflow   = credit & ~send & (count == FULL);
        count_next = (send & ~credit) ? count - CW'(1) :
                     (~send & credit & ~overflow) ? count + CW'(1) : count;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= FULL;
        else      count <= count_next;

endmodule

// File: rtl/credit_flit_sender.sv
// credit_flit_sender: per-VC credit tracking and packet-order check, registered flit forward.
// CREDIT_BYPASS_EN lets a same-cycle returning credit enable a send at zero credits.
module credit_flit_sender
    import noc_link_pkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_SIZE   = 8,
    parameter int VC_NUM      = 2,
    localparam int VC_SIZE    = vc_width(VC_NUM),
    localparam int CW         = credit_width(BUFFER_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic [1:0]           flit_type_i,
    input  logic [VC_SIZE-1:0]   vc_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [VC_NUM-1:0]    credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic [1:0]           flit_type_o,
    output logic [VC_SIZE-1:0]   vc_o,
    output logic                 valid_o,
    output logic [VC_NUM-1:0]    vc_idle_o,
    output logic                 error_o
);

    logic [CW-1:0]     credit [VC_NUM];
    logic [VC_NUM-1:0] send, overflow;
    vc_state_t         state [VC_NUM], state_next [VC_NUM];
    flit_type_t        ft;
    logic              legal, accept, fwd;

    always_comb begin
        ft     = flit_type_t'(flit_type_i);
        legal  = (state[vc_i] == IDLE) ? (ft == HEAD || ft == HEADTAIL) : (ft == BODY || ft == TAIL);
`ifdef CREDIT_BYPASS_EN
        ready_o = (credit[vc_i] != '0) | credit_i[vc_i];
`else
        ready_o = credit[vc_i] != '0;
`endif
        accept = valid_i & ready_o;
        fwd    = accept & legal;
        for (int i = 0; i < VC_NUM; i++) send[i] = fwd && (vc_i == VC_SIZE'(i));
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_cc
        credit_counter #(.BUFFER_SIZE(BUFFER_SIZE)) u_cc (
            .clk     (clk),
            .rst     (rst),
            .send    (send[v]),
            .credit  (credit_i[v]),
            .count   (credit[v]),
            .overflow(overflow[v])
        );
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) for (int i = 0; i < VC_NUM; i++) state[i] <= IDLE;
        else      for (int i = 0; i < VC_NUM; i++) state[i] <= state_next[i];

    // only legal flits reach send, so HEAD always opens and TAIL always closes
    always_comb
        for (int i = 0; i < VC_NUM; i++)
            state_next[i] = !send[i] ? state[i] : (ft == HEAD) ? ACTIVE : (ft == TAIL) ? IDLE : state[i];

    always_comb
        for (int i = 0; i < VC_NUM; i++) vc_idle_o[i] = state[i] == IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid_o     <= 1'b0;
            data_o      <= '0;
            flit_type_o <= '0;
            vc_o        <= '0;
            error_o     <= 1'b0;
        end else begin
            valid_o <= fwd;
            if (fwd) begin
                data_o      <= data_i;
                flit_type_o <= flit_type_i;
                vc_o        <= vc_i;
            end
            error_o <= error_o | (accept & ~legal) | (|overflow);
        end

endmodule

// File: tb/tb_credit_flit_sender.sv
// tb_credit_flit_sender: vector table, directed corner sequences and a randomized occupancy model
module tb_credit_flit_sender;
    import noc_link_pkg::*;

    localparam int BS = 8;

    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] data_i = '0, data_o;
    logic [1:0] flit_type_i = '0, flit_type_o;
    logic       vc_i = 1'b0, vc_o;
    logic       valid_i = 1'b0, ready_o, valid_o, error_o;
    logic [1:0] credit_i = '0, vc_idle_o;

    credit_flit_sender #(.BUFFER_SIZE(BS), .FLIT_SIZE(8), .VC_NUM(2)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .flit_type_i(flit_type_i), .vc_i(vc_i),
        .valid_i(valid_i), .ready_o(ready_o), .credit_i(credit_i), .data_o(data_o),
        .flit_type_o(flit_type_o), .vc_o(vc_o), .valid_o(valid_o), .vc_idle_o(vc_idle_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic c, input logic [7:0] d,
                         input logic [1:0] cr);
        @(negedge clk);
        valid_i = v; flit_type_i = t; vc_i = c; data_i = d; credit_i = cr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0; credit_i = '0; data_i = '0; flit_type_i = '0; vc_i = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_idle", 32'(vc_idle_o), 3);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_c0", 32'(dut.credit[0]), BS);
        chk("rst_c1", 32'(dut.credit[1]), BS);
        rst = 1'b1;
    endtask

    typedef struct {
        logic v; logic [1:0] t; logic vc; logic [7:0] d; logic [1:0] cr;
        logic rdy; logic vo; logic [1:0] idle; logic err; int c0; int c1;
    } vec_t;
    vec_t tbl[11];

    int occ[2];
    bit act[2];
    bit merr, m_vo, m_rdy, m_s;
    logic [7:0] m_d;
    logic [1:0] m_t;
    logic m_vc;

    initial begin
        tbl[0]  = '{1'b1, HEAD,     1'b0, 8'hA1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 7, 8};
        tbl[1]  = '{1'b1, BODY,     1'b0, 8'hA2, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 6, 8};
        tbl[2]  = '{1'b1, TAIL,     1'b0, 8'hA3, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 5, 8};
        tbl[3]  = '{1'b0, HEAD,     1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 5, 8};
        tbl[4]  = '{1'b1, HEAD,     1'b0, 8'hB1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 4, 8};
        tbl[5]  = '{1'b1, HEAD,     1'b1, 8'hB2, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 4, 7};
        tbl[6]  = '{1'b1, TAIL,     1'b0, 8'hB3, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 3, 7};
        tbl[7]  = '{1'b1, TAIL,     1'b1, 8'hB4, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 3, 6};
        tbl[8]  = '{1'b1, HEADTAIL, 1'b0, 8'hC1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 3, 6};
        tbl[9]  = '{1'b0, HEAD,     1'b1, 8'h00, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 3, 7};
        tbl[10] = '{1'b1, BODY,     1'b0, 8'hD1, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 3, 7};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].vc, tbl[i].d, tbl[i].cr);
            #1 chk($sformatf("v%0d_ready", i), 32'(ready_o), 32'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_o", i), 32'(valid_o), 32'(tbl[i].vo));
            if (tbl[i].vo) begin
                chk($sformatf("v%0d_data", i), 32'(data_o), 32'(tbl[i].d));
                chk($sformatf("v%0d_type", i), 32'(flit_type_o), 32'(tbl[i].t));
                chk($sformatf("v%0d_vc", i), 32'(vc_o), 32'(tbl[i].vc));
            end
            chk($sformatf("v%0d_idle", i), 32'(vc_idle_o), 32'(tbl[i].idle));
            chk($sformatf("v%0d_err", i), 32'(error_o), 32'(tbl[i].err));
            chk($sformatf("v%0d_c0", i), 32'(dut.credit[0]), 32'(tbl[i].c0));
            chk($sformatf("v%0d_c1", i), 32'(dut.credit[1]), 32'(tbl[i].c1));
        end
        drive(1'b0, HEAD, 1'b0, 8'h00, 2'b00);
        @(posedge clk); #1 chk("err_sticky_tbl", 32'(error_o), 1);

        // credit exhaustion on VC1
        do_reset();
        for (int k = 0; k < BS; k++) begin
            drive(1'b1, HEADTAIL, 1'b1, 8'(k + 16), 2'b00);
            @(posedge clk);
        end
        drive(1'b1, HEADTAIL, 1'b1, 8'hFF, 2'b00);
        #1 chk("exh_ready0", 32'(ready_o), 0);
        @(posedge clk); #1;
        chk("exh_valid_o", 32'(valid_o), 0);
        chk("exh_c1", 32'(dut.credit[1]), 0);
        drive(1'b0, HEADTAIL, 1'b1, 8'h00, 2'b10);
`ifdef CREDIT_BYPASS_EN
        #1 chk("exh_ready_bypass", 32'(ready_o), 1);
`else
        #1 chk("exh_ready_nobypass", 32'(ready_o), 0);
`endif
        drive(1'b0, HEADTAIL, 1'b1, 8'h00, 2'b00);
        #1 chk("exh_ready_next", 32'(ready_o), 1);
        chk("exh_c1_after", 32'(dut.credit[1]), 1);
        chk("exh_err", 32'(error_o), 0);

        // overflow at full credit
        do_reset();
        drive(1'b0, HEAD, 1'b0, 8'h00, 2'b01);
        @(posedge clk); #1;
        chk("ovf_err", 32'(error_o), 1);
        chk("ovf_c0", 32'(dut.credit[0]), BS);
        drive(1'b0, HEAD, 1'b0, 8'h00, 2'b00);
        repeat (3) @(posedge clk);
        #1 chk("ovf_sticky", 32'(error_o), 1);

        // HEAD on an active VC1 is dropped
        do_reset();
        drive(1'b1, HEAD, 1'b1, 8'h11, 2'b00);
        drive(1'b1, HEAD, 1'b1, 8'hEE, 2'b00);
        #1 chk("ill_ready", 32'(ready_o), 1);
        @(posedge clk); #1;
        chk("ill_valid_o", 32'(valid_o), 0);
        chk("ill_err", 32'(error_o), 1);
        chk("ill_c1", 32'(dut.credit[1]), 7);
        chk("ill_idle", 32'(vc_idle_o), 1);
        chk("ill_data_hold", 32'(data_o), 8'h11);

        // asynchronous reset mid-packet
        do_reset();
        drive(1'b1, HEAD, 1'b0, 8'h55, 2'b00);
        @(posedge clk); #1 chk("mid_head_valid", 32'(valid_o), 1);
        drive(1'b1, BODY, 1'b0, 8'h56, 2'b00);
        #2 rst = 1'b0;
        #1;
        chk("mid_valid_o", 32'(valid_o), 0);
        chk("mid_idle", 32'(vc_idle_o), 3);
        chk("mid_c0", 32'(dut.credit[0]), BS);
        @(posedge clk); #1 chk("mid_valid_o_edge", 32'(valid_o), 0);

        // randomized against occupancy model
        do_reset();
        occ = '{0, 0}; act = '{0, 0}; merr = 0; m_d = '0; m_t = '0; m_vc = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic v, c;
            logic [1:0] t, cr;
            v = $urandom_range(0, 3) != 0;
            c = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(0, 3));
            else if (act[c]) t = $urandom_range(0, 1) ? BODY : TAIL;
            else t = $urandom_range(0, 1) ? HEAD : HEADTAIL;
            for (int k = 0; k < 2; k++)
                cr[k] = occ[k] > 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 80) == 0);
            drive(v, t, c, 8'($urandom), cr);
`ifdef CREDIT_BYPASS_EN
            m_rdy = occ[c] < BS || cr[c];
`else
            m_rdy = occ[c] < BS;
`endif
            #1 chk("rnd_ready", 32'(ready_o), 32'(m_rdy));
            m_vo = 0;
            if (v && m_rdy) begin
                if (act[c] ? (t == BODY || t == TAIL) : (t == HEAD || t == HEADTAIL)) begin
                    m_vo = 1; m_d = data_i; m_t = t; m_vc = c;
                    if (t == HEAD) act[c] = 1;
                    if (t == TAIL) act[c] = 0;
                end else merr = 1;
            end
            for (int k = 0; k < 2; k++) begin
                m_s = m_vo && m_vc == 1'(k);
                if (m_s && !cr[k]) occ[k]++;
                else if (!m_s && cr[k]) begin
                    if (occ[k] == 0) merr = 1;
                    else occ[k]--;
                end
            end
            @(posedge clk); #1;
            chk("rnd_valid_o", 32'(valid_o), 32'(m_vo));
            chk("rnd_data", 32'(data_o), 32'(m_d));
            chk("rnd_type", 32'(flit_type_o), 32'(m_t));
            chk("rnd_vc", 32'(vc_o), 32'(m_vc));
            chk("rnd_idle", 32'(vc_idle_o), 32'({~act[1], ~act[0]}));
            chk("rnd_err", 32'(error_o), 32'(merr));
            chk("rnd_c0", 32'(dut.credit[0]), 32'(BS - occ[0]));
            chk("rnd_c1", 32'(dut.credit[1]), 32'(BS - occ[1]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
